// File: rtl/handshake_rr_arb.sv
// handshake_rr_arb: round-robin arbiter sharing one registered valid/ready output stage among NumReq requesters.
// Optional packet locking is compiled in with `define HS_ARB_LOCK_EN (adds the ReqLast port).
module handshake_rr_arb #(
   parameter int Depth  = 10,
   parameter int NumReq = 4,
   localparam int IdW   = $clog2(NumReq)
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic [NumReq*Depth-1:0] ReqData,
   input  logic [NumReq-1:0]       ReqVld,
   output logic [NumReq-1:0]       ReqRdy,
`ifdef HS_ARB_LOCK_EN
   input  logic [NumReq-1:0]       ReqLast,
`endif
   output logic [Depth-1:0]        DataOut,
   output logic                    DataOutVld,
   input  logic                    DataOutRdy,
   output logic [IdW-1:0]          GrantId
);

   logic [Depth-1:0] r_data;
   logic             r_vld;
   logic [IdW-1:0]   r_gid;
   logic [IdW-1:0]   r_lastGnt;

`ifdef HS_ARB_LOCK_EN
   typedef enum logic {IDLE, LOCKED} lockState_t;
   lockState_t     r_lockState;
   logic [IdW-1:0] r_lockId;
`endif

   logic [Depth-1:0] w_words [NumReq];
   logic [IdW-1:0]   w_idx;
   logic [IdW-1:0]   w_sel;
   logic             w_any;
   logic             w_accept;
   logic             w_xfer;

   for (genvar g = 0; g < NumReq; g++) begin : g_unpack
      assign w_words[g] = ReqData[g*Depth +: Depth];
   end

   assign w_accept = !r_vld || DataOutRdy;

   // Walk the requesters starting just after the last grant; a held lock overrides the search.
   always_comb begin
      w_sel = r_lastGnt;
      w_any = 1'b0;
      w_idx = r_lastGnt;
      for (int k = 0; k < NumReq; k++) begin
         w_idx = (w_idx == IdW'(NumReq - 1)) ? '0 : w_idx + IdW'(1);
         if (!w_any && ReqVld[w_idx]) begin
            w_any = 1'b1;
            w_sel = w_idx;
         end
      end
`ifdef HS_ARB_LOCK_EN
      if (r_lockState == LOCKED) begin
         w_sel = r_lockId;
         w_any = ReqVld[r_lockId];
      end
`endif
   end

   assign w_xfer = w_accept && w_any && !Rst;
   assign ReqRdy = w_xfer ? (NumReq'(1) << w_sel) : '0;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_data    <= '0;
         r_vld     <= 1'b0;
         r_gid     <= '0;
         r_lastGnt <= IdW'(NumReq - 1);
`ifdef HS_ARB_LOCK_EN
         r_lockState <= IDLE;
         r_lockId    <= '0;
`endif
      end else if (w_xfer) begin
         r_data    <= w_words[w_sel];
         r_vld     <= 1'b1;
         r_gid     <= w_sel;
         r_lastGnt <= w_sel;
`ifdef HS_ARB_LOCK_EN
         // A beat without ReqLast keeps the grant on this requester until its last beat.
         if (ReqLast[w_sel]) begin
            r_lockState <= IDLE;
         end else begin
            r_lockState <= LOCKED;
            r_lockId    <= w_sel;
         end
`endif
      end else if (DataOutRdy) begin
         r_vld <= 1'b0;
      end
   end

   assign DataOut    = r_data;
   assign DataOutVld = r_vld;
   assign GrantId    = r_gid;

endmodule

// File: doc/handshake_rr_arb.md
# handshake_rr_arb

Round-robin arbiter that shares a single valid/ready output stage between `NumReq` requesters. Each requester presents data under a valid/ready handshake. The arbiter selects one requester per cycle and captures its word into a one-entry registered output stage. That stage drives the downstream `DataOut`/`DataOutVld`/`DataOutRdy` handshake. It sits in front of any single-consumer handshake datapath that must be fed by several producers.

## Interface
- `Depth`, 10, data word width in bits.
- `NumReq`, 4, number of requesters; legal range 2..16.
- `IdW`, `$clog2(NumReq)`, width of the grant index (localparam, derived).

- `Clk`  in  1  single clock; all logic on posedge.
- `Rst`  in  1  reset, synchronous, active-high.
- `ReqData`  in  `NumReq*Depth`  requester words; requester i occupies bits `[i*Depth +: Depth]`.
- `ReqVld`  in  `NumReq`  per-requester valid.
- `ReqRdy`  out  `NumReq`  per-requester ready; at most one bit high per cycle.
- `ReqLast`  in  `NumReq`  per-requester last-beat flag; present only with `HS_ARB_LOCK_EN`.
- `DataOut`  out  `Depth`  registered output word.
- `DataOutVld`  out  1  output valid (registered).
- `DataOutRdy`  in  1  downstream ready.
- `GrantId`  out  `IdW`  index of the requester whose word is in `DataOut` (registered, changes together with `DataOut`).

## Operation
- A transfer on any port occurs when vld and rdy are both high at a posedge.
- Stage can accept when it is empty or being drained in the same cycle:
  - `accept = !DataOutVld || DataOutRdy`.
- Round-robin pointer `LastGnt` (IdW bits) holds the index of the most recently accepted requester.
- Arbitration (combinational):
  - Search `ReqVld` starting at `(LastGnt+1) mod NumReq`, wrapping.
  - The first set bit wins; the winner index is `Sel`.
- `ReqRdy[Sel] = accept && |ReqVld`; all other `ReqRdy` bits are 0. `ReqRdy` is 0 for every requester whose `ReqVld` is low.
- On a requester transfer:
  - `DataOut <= ReqData[Sel]`, `GrantId <= Sel`, `DataOutVld <= 1`, `LastGnt <= Sel`.
- Output drained with no requester transfer: `DataOutVld <= 0`. `DataOut` and `GrantId` hold their last values.
- `DataOutVld && !DataOutRdy`: `DataOut`, `GrantId` and `DataOutVld` are held stable, and all `ReqRdy` bits are 0.
- Simultaneous drain and fill in the same cycle: the new word replaces the old one and `DataOutVld` stays 1. There is no bubble.
- A single active requester is granted every cycle, with no idle cycles inserted.
- Fairness: with all requesters continuously valid and `DataOutRdy` held at 1, grants rotate 0,1,2,...,NumReq-1,0,...
- Reset values:
  - `DataOutVld = 0`, `DataOut = 0`, `GrantId = 0`.
  - `LastGnt = NumReq-1`, so requester 0 has first priority.
  - `ReqRdy = 0` during reset.
- Reset asserted mid-operation: the word held in the output stage is discarded. Any in-progress lock (see Configuration) is cleared, and the pointer returns to `NumReq-1`.

## Timing
- Latency is 1 cycle: a requester transfer at edge N gives `DataOutVld = 1` with that word after edge N.
- Throughput is one word per cycle when `DataOutRdy` is held high.
- `ReqRdy` is combinational from `ReqVld`, `DataOutVld`, `DataOutRdy` and the lock state. It must not depend on `ReqData`.
- `DataOut`, `DataOutVld` and `GrantId` are driven directly from flops.
- Upstream rule: a requester must hold `ReqVld` and `ReqData` until it sees `ReqRdy`. The arbiter does not rely on this rule for correctness, but the bench checks it.

## Configuration
- Macro: `HS_ARB_LOCK_EN`.
- Defined:
  - The `ReqLast` port exists.
  - When requester i transfers a beat with `ReqLast[i]=0`, the grant locks to i.
  - While locked, arbitration is bypassed and only i can receive `ReqRdy`. The lock holds even if `ReqVld[i]` drops, and other requesters wait.
  - The lock releases after the beat with `ReqLast[i]=1` transfers. `LastGnt` updates on that beat.
  - A single-beat packet (`ReqLast=1` on its first beat) takes no lock.
  - The lock state is 2 states, IDLE and LOCKED(id), and resets to IDLE.
- Undefined: `ReqLast` is absent and arbitration is per beat, as described in Operation.

## Test plan
- Reset, then `ReqVld=4'b0000` for 5 cycles -> `DataOutVld=0`, `DataOut=0`, `GrantId=0`, `ReqRdy=0`.
- All four requesters valid, with `ReqData[i] = 10'h100+i`, and `DataOutRdy=1` for 8 cycles -> `GrantId` sequence 0,1,2,3,0,1,2,3, `DataOut` 100h..103h repeating, `DataOutVld` continuously 1.
- Only requester 2 valid, `DataOutRdy=1` for 4 cycles -> `ReqRdy=4'b0100` every cycle, with 4 consecutive outputs and `GrantId=2`.
- Output full, then `DataOutRdy=0` for 3 cycles while requesters 0 and 1 are valid -> `DataOut`/`GrantId` stable and `ReqRdy=0`. When `DataOutRdy` returns to 1, the next grant is the requester after the held `GrantId`.
- `Rst` pulsed for 1 cycle while `DataOutVld=1` and the pointer is at 2 -> next cycle `DataOutVld=0`, and the first post-reset grant goes to requester 0.
- With `HS_ARB_LOCK_EN`: requester 1 sends 3 beats with `ReqLast=0,0,1` while requester 0 is also valid -> outputs from requester 1 ×3 are contiguous (even across a 1-cycle `ReqVld[1]` gap), then requester 2/3/0 follows per the round-robin order.
